// File: rtl/coin_dispenser.sv
// coin_dispenser: turns a credit amount (nickel units) into a greedy sequence
// of dime/nickel eject requests, one valid/ack handshake per coin, with a
// settle gap of GAP_CYCLES idle cycles after every acked coin.
//
// Optional feature macro: COIN_TIMEOUT_EN
//   defined   -> SEND aborts after TIMEOUT cycles without coin_ack, sets the
//                sticky fault flag and blocks further starts until reset.
//   undefined -> no timeout counter; fault is tied to 0, SEND waits forever.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   dispense request, sampled in IDLE only
//   amount     in   credit to return in nickels, sampled with start
//   coin_ack   in   mechanism has ejected the presented coin
//   coin       out  01 nickel, 10 dime, 00 when not presenting
//   coin_valid out  coin is being presented
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion (or abort) pulse
//   fault      out  sticky timeout flag
//   Out_state  out  current FSM state code for debug/LEDs
module coin_dispenser #(
  parameter int AMT_W      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  output logic [1:0]       coin,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [2:0]       Out_state
);

  if (GAP_CYCLES < 0 || GAP_CYCLES > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("coin_dispenser: GAP_CYCLES must be 0..255 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    GAP  = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [7:0]       gap_q, gap_d;

  // Greedy choice: a dime whenever at least two nickels remain, so a nickel
  // is only ever issued with rem==1 and rem cannot underflow.
  logic             is_dime;
  logic [AMT_W-1:0] rem_after;
  assign is_dime   = (rem_q > AMT_W'(1));
  assign rem_after = rem_q - (is_dime ? AMT_W'(2) : AMT_W'(1));

  logic timeout_hit;
  logic start_ok;

`ifdef COIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            fault_q, fault_d;

  // Counts unacked SEND cycles; anything else (ack, other states) clears it,
  // so every entry into SEND starts from zero.
  always_comb begin
    to_d        = '0;
    timeout_hit = 1'b0;
    if (state_q == SEND && !coin_ack) begin
      if (to_q == TO_W'(TIMEOUT - 1)) timeout_hit = 1'b1;
      else                            to_d        = to_q + TO_W'(1);
    end
    fault_d = fault_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      to_q    <= to_d;
      fault_q <= fault_d;
    end
  end

  assign start_ok = start & ~fault_q;
  assign fault    = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign start_ok    = start;
  assign fault       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (amount != '0) begin
            rem_d   = amount;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (coin_ack) begin
          rem_d = rem_after;
          if (rem_after == '0)      state_d = DONE;
          else if (GAP_CYCLES == 0) state_d = SEND;
          else begin
            state_d = GAP;
            gap_d   = 8'(GAP_CYCLES);
          end
        end else if (timeout_hit) begin
          rem_d   = '0;
          state_d = DONE;
        end
      end
      GAP: begin
        // Leaving on the count==1 cycle yields exactly GAP_CYCLES idle cycles.
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = SEND;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
    end
  end

  // Moore outputs: decoded from registered state and rem only.
  assign coin_valid = (state_q == SEND);
  assign coin       = (state_q == SEND) ? (is_dime ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign Out_state  = state_q;

endmodule

// File: doc/coin_dispenser.md
Name: coin_dispenser

Overview:
- Change/coin-return dispenser for the vending datapath; the transmit side of the 2-bit coin code the coin-accept FSM receives (01 = nickel, 10 = dime, 00 = none).
- Takes a credit amount in nickel units and emits it as a greedy sequence of dime/nickel requests to the coin-eject mechanism.
- Each coin uses a valid/ack handshake, followed by a mandatory settle gap.
- Sits between the vend controller (start/amount/done) and the eject solenoid driver (coin/coin_valid/coin_ack).

Parameters:
- AMT_W, 4: width of amount and of the remaining-credit register, in nickel units.
- GAP_CYCLES, 2: idle cycles after each acked coin, before the next coin is presented. Legal range is 0 to 255.
- TIMEOUT, 15: maximum cycles to wait for coin_ack. Used only with COIN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to dispense; sampled only in IDLE.
- amount  in  AMT_W  credit to return, in nickels; sampled with start.
- coin_ack  in  1  mechanism has ejected the presented coin.
- coin  out  2  coin code: 01 nickel, 10 dime, 00 when coin_valid=0.
- coin_valid  out  1  coin is being presented.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the dispense completes (or aborts).
- fault  out  1  sticky timeout flag; constant 0 without COIN_TIMEOUT_EN.
- Out_state  out  3  current FSM state, for debug/LEDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rem=0, gap counter=0, timeout counter=0.
  - coin=00, coin_valid=0, busy=0, done=0, fault=0.
  - Applies immediately, including mid-handshake; any coin being presented is dropped the same instant.
- Moore machine. Every output is decoded from the registered state plus the rem register only; no input-to-output combinational path.
- State encoding: IDLE=0, SEND=1, GAP=2, DONE=3. Codes 4-7 are illegal and return to IDLE on the next edge.
- IDLE:
  - start=1 and amount!=0: rem<=amount, go to SEND.
  - start=1 and amount==0: go to DONE.
  - Otherwise stay in IDLE.
- SEND:
  - coin_valid=1; coin=10 if rem>=2, else 01.
  - coin is held stable until coin_ack. Without the timeout feature, the FSM waits indefinitely.
  - On coin_ack=1: rem decrements by 2 (dime) or 1 (nickel).
    - If the new rem is 0: go to DONE.
    - Else if GAP_CYCLES=0: stay in SEND; the next coin is presented in the following cycle.
    - Else: go to GAP and load the gap counter with GAP_CYCLES.
- GAP:
  - coin_valid=0.
  - Counter decrements each cycle; leave for SEND on the cycle it reaches 1.
  - This gives exactly GAP_CYCLES cycles with coin_valid=0 between coins.
  - coin_ack in GAP is ignored.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy=1.
- Latency:
  - First coin_valid appears 1 cycle after start is sampled.
  - done rises 1 cycle after the final ack.
  - amount=0 gives done 1 cycle after start.
- start while busy is ignored; no queuing.
- coin_ack in IDLE or DONE is ignored.
- rem never underflows: a nickel is issued only when rem==1.
- Coin count is ceil(amount/2): amount/2 dimes, plus one nickel if amount is odd.

Optional Feature:
- Macro: COIN_TIMEOUT_EN.
- Defined:
  - In SEND, a counter increments each cycle without ack and is cleared on entry to SEND.
  - If it reaches TIMEOUT without ack: fault<=1 (sticky until reset), rem<=0, go to DONE. done still pulses.
  - While fault=1, start is ignored.
- Undefined:
  - No counter logic is synthesised.
  - fault is tied to 0 and SEND waits indefinitely.

Test Plan:
- amount=5, start pulse, coin_ack 1 cycle after each coin_valid, GAP_CYCLES=2 -> coins 10, 10, 01 with exactly 2 idle cycles between them; done pulses once, 1 cycle after the third ack; busy falls with IDLE.
- amount=0, start pulse -> no coin_valid; done high 1 cycle after start; Out_state sequence 0,3,0.
- amount=1 with ack delayed 4 cycles -> coin=01 and coin_valid held stable for all 5 cycles; rem goes to 0; done follows.
- reset asserted mid-SEND (second coin of amount=4), no clock edge -> coin_valid=0, busy=0, coin=00 immediately. After release, start with amount=2 -> single dime.
- start pulsed again during an active amount=6 dispense with amount=1 -> ignored; exactly three dimes issued.
- COIN_TIMEOUT_EN, TIMEOUT=15, amount=3, never ack -> coin=10 held 15 cycles, then fault=1 and done pulses; further starts are ignored until reset.
